// File: rtl/ysyx_22040386_csr.sv
// ysyx_22040386_csr: M-mode CSR file, free-running mcycle and ecall/mret trap sequencer.
// Reads and redirect are combinational; all updates commit at the rising edge.
module ysyx_22040386_csr #(
    parameter logic [63:0] MCAUSE_ECALL = 64'd11,
    parameter logic [63:0] MSTATUS_RST = 64'h0000_0000_0000_1800
) (
    input  logic        i_CSR_clk,
    input  logic        i_CSR_rst,
    input  logic        i_CSR_valid,
    input  logic [1:0]  i_CSR_state,
    input  logic        i_CSR_ren,
    input  logic        i_CSR_wen,
    input  logic [11:0] i_CSR_raddr,
    input  logic [11:0] i_CSR_waddr,
    input  logic [2:0]  i_CSR_funct3,
    input  logic [4:0]  i_CSR_rs1_addr,
    input  logic [63:0] i_CSR_wdata,
    input  logic [63:0] i_CSR_pc,
    output logic [63:0] o_CSR_rdata,
    output logic        o_CSR_redirect,
    output logic [63:0] o_CSR_npc
);
    localparam logic [1:0] ST_RW = 2'b01;
    localparam logic [1:0] ST_ECALL = 2'b10;
    localparam logic [1:0] ST_MRET = 2'b11;

    // slots: 0 mstatus, 1 mie, 2 mtvec, 3 mscratch, 4 mepc, 5 mcause, 6 mip, 7 mcycle
    logic [63:0] csr [8];
    logic [3:0]  rsel, wsel;
    logic [63:0] old, wval, ms;
    logic        wr;

    // {hit, slot} for a CSR address
    function automatic logic [3:0] sel(input logic [11:0] a);
        case (a)
            12'h300: sel = 4'b1000;
            12'h304: sel = 4'b1001;
            12'h305: sel = 4'b1010;
            12'h340: sel = 4'b1011;
            12'h341: sel = 4'b1100;
            12'h342: sel = 4'b1101;
            12'h344: sel = 4'b1110;
            12'hB00: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
    endfunction

    always_comb begin
        rsel = sel(i_CSR_raddr);
        wsel = sel(i_CSR_waddr);
        old = wsel[3] ? csr[wsel[2:0]] : '0;
        ms = csr[0];
        wval = i_CSR_funct3 == 3'b001 ? i_CSR_wdata :
               i_CSR_funct3 == 3'b010 ? (old | i_CSR_wdata) : (old & ~i_CSR_wdata);
        // set/clear with x0 as source must not write
        wr = i_CSR_valid && i_CSR_state == ST_RW && wsel[3] &&
             (i_CSR_funct3 == 3'b001 ||
              ((i_CSR_funct3 == 3'b010 || i_CSR_funct3 == 3'b011) && i_CSR_rs1_addr != 5'd0));
        o_CSR_rdata = (i_CSR_ren && rsel[3]) ? csr[rsel[2:0]] : '0;
        o_CSR_redirect = i_CSR_state[1];
        o_CSR_npc = i_CSR_state == ST_ECALL ? {csr[2][63:2], 2'b00} :
                    i_CSR_state == ST_MRET ? csr[4] : '0;
    end

    always_ff @(posedge i_CSR_clk) begin
        if (i_CSR_rst) begin
            for (int i = 0; i < 8; i++) csr[i] <= (i == 0) ? MSTATUS_RST : '0;
        end else begin
            csr[7] <= csr[7] + 64'd1;
            if (wr) csr[wsel[2:0]] <= wval;
            if (i_CSR_valid && i_CSR_state == ST_ECALL) begin
                csr[4] <= i_CSR_pc;
                csr[5] <= MCAUSE_ECALL;
                csr[0] <= {ms[63:13], 2'b11, ms[10:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
            end
            if (i_CSR_valid && i_CSR_state == ST_MRET)
                csr[0] <= {ms[63:13], 2'b11, ms[10:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
        end
    end

    // decode raises wen only for csr rw or ecall
    assert property (@(posedge i_CSR_clk) disable iff (i_CSR_rst)
        (i_CSR_valid && i_CSR_wen) |-> (i_CSR_state == ST_RW || i_CSR_state == ST_ECALL));
endmodule

// File: tb/tb_ysyx_22040386_csr.sv
// tb_ysyx_22040386_csr: directed and random checks of the CSR file against an
// address-keyed reference model.
module tb_ysyx_22040386_csr;
    logic        clk = 0, rst = 0, valid = 0, ren = 0, wen = 0;
    logic [1:0]  state = 0;
    logic [11:0] raddr = 0, waddr = 0;
    logic [2:0]  f3 = 0;
    logic [4:0]  rs1 = 0;
    logic [63:0] wdata = 0, pc = 0;
    logic [63:0] rdata, npc;
    logic        redirect;
    int checks = 0, failures = 0;
    logic [63:0] m [logic [11:0]];
    logic [63:0] last_rdata, last_npc;
    logic        last_redir;
    logic [11:0] addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'h7C0};

    ysyx_22040386_csr dut (
        .i_CSR_clk(clk), .i_CSR_rst(rst), .i_CSR_valid(valid), .i_CSR_state(state),
        .i_CSR_ren(ren), .i_CSR_wen(wen), .i_CSR_raddr(raddr), .i_CSR_waddr(waddr),
        .i_CSR_funct3(f3), .i_CSR_rs1_addr(rs1), .i_CSR_wdata(wdata), .i_CSR_pc(pc),
        .o_CSR_rdata(rdata), .o_CSR_redirect(redirect), .o_CSR_npc(npc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd_model(input logic [11:0] a);
        return m.exists(a) ? m[a] : 64'd0;
    endfunction

    task automatic model_reset();
        m.delete();
        foreach (addrs[i]) if (addrs[i] != 12'h7C0) m[addrs[i]] = 64'd0;
        m[12'h300] = 64'h1800;
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic r, input logic [11:0] ra,
                         input logic [11:0] wa, input logic [2:0] fn, input logic [4:0] s1,
                         input logic [63:0] wd, input logic [63:0] p);
        valid = v; state = st; ren = r; raddr = ra; waddr = wa;
        f3 = fn; rs1 = s1; wdata = wd; pc = p;
        wen = (st == 2'b01 && fn == 3'b001) || st == 2'b10;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        model_reset();
        #1 rst = 0;
    endtask

    // one instruction cycle: check combinational outputs, then apply the model at the edge
    task automatic step(input logic v, input logic [1:0] st, input logic r, input logic [11:0] ra,
                        input logic [11:0] wa, input logic [2:0] fn, input logic [4:0] s1,
                        input logic [63:0] wd, input logic [63:0] p);
        logic [63:0] nm [logic [11:0]];
        logic [63:0] old, ms;
        drive(v, st, r, ra, wa, fn, s1, wd, p);
        #2;
        last_rdata = rdata; last_redir = redirect; last_npc = npc;
        check("rdata", rdata, r ? rd_model(ra) : 64'd0);
        check("redirect", {63'd0, redirect}, {63'd0, st[1]});
        check("npc", npc, st == 2'b10 ? (m[12'h305] & ~64'd3) : st == 2'b11 ? m[12'h341] : 64'd0);
        nm = m;
        nm[12'hB00] = m[12'hB00] + 64'd1;
        old = rd_model(wa);
        if (v && st == 2'b01 && m.exists(wa)) begin
            if (fn == 3'b001) nm[wa] = wd;
            else if (fn == 3'b010 && s1 != 0) nm[wa] = old | wd;
            else if (fn == 3'b011 && s1 != 0) nm[wa] = old & ~wd;
        end
        ms = m[12'h300];
        if (v && st == 2'b10) begin
            nm[12'h341] = p;
            nm[12'h342] = 64'd11;
            ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
            nm[12'h300] = ms;
        end
        if (v && st == 2'b11) begin
            ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
            nm[12'h300] = ms;
        end
        @(posedge clk);
        m = nm;
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        step(0, 2'b00, 1, a, 12'h0, 3'b000, 5'd0, 64'd0, 64'd0);
    endtask

    task automatic csrw(input logic [11:0] a, input logic [2:0] fn, input logic [4:0] s1, input logic [63:0] d);
        step(1, 2'b01, 0, 12'h0, a, fn, s1, d, 64'd0);
    endtask

    initial begin
        model_reset();
        do_reset();
        rd(12'h300); check("rst_mstatus", last_rdata, 64'h1800);
        rd(12'h305); check("rst_mtvec", last_rdata, 64'd0);
        rd(12'hB00); rd(12'hB00);
        rd(12'hB00); check("mcycle_5th", last_rdata, 64'd4);
        // write during reset has no effect
        drive(1, 2'b01, 0, 12'h0, 12'h305, 3'b001, 5'd3, 64'h1234, 64'd0);
        do_reset();
        rd(12'h305); check("rst_wr_ignored", last_rdata, 64'd0);

        csrw(12'h305, 3'b001, 5'd1, 64'h8000_0104);
        rd(12'h305); check("csrrw_mtvec", last_rdata, 64'h8000_0104);
        csrw(12'h340, 3'b010, 5'd5, 64'hF0);
        csrw(12'h340, 3'b010, 5'd0, 64'hFF);
        rd(12'h340); check("csrrs_x0", last_rdata, 64'hF0);
        csrw(12'h340, 3'b011, 5'd6, 64'h30);
        rd(12'h340); check("csrrc", last_rdata, 64'hC0);

        csrw(12'h305, 3'b001, 5'd1, 64'h8000_0101);
        csrw(12'h300, 3'b010, 5'd1, 64'h8);
        step(1, 2'b10, 0, 12'h0, 12'h0, 3'b000, 5'd0, 64'd0, 64'h8000_0010);
        check("ecall_redir", {63'd0, last_redir}, 64'd1);
        check("ecall_npc", last_npc, 64'h8000_0100);
        step(1, 2'b11, 1, 12'h300, 12'h0, 3'b000, 5'd0, 64'd0, 64'd0);
        check("ecall_mstatus", last_rdata, 64'h1880);
        check("mret_npc", last_npc, 64'h8000_0010);
        rd(12'h341); check("mepc", last_rdata, 64'h8000_0010);
        rd(12'h342); check("mcause", last_rdata, 64'd11);
        rd(12'h300); check("mret_mstatus", last_rdata, 64'h1888);

        csrw(12'hB00, 3'b001, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hB00); check("mcycle_max", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hB00); check("mcycle_wrap", last_rdata, 64'd0);
        csrw(12'hB00, 3'b001, 5'd1, 64'd5);
        rd(12'hB00); check("mcycle_wr_wins", last_rdata, 64'd5);

        csrw(12'h7C0, 3'b001, 5'd1, 64'hDEAD);
        rd(12'h7C0); check("unimpl", last_rdata, 64'd0);
        step(0, 2'b10, 0, 12'h0, 12'h0, 3'b000, 5'd0, 64'd0, 64'h4444);
        check("inv_redir", {63'd0, last_redir}, 64'd1);
        rd(12'h341); check("inv_mepc", last_rdata, 64'h8000_0010);

        step(1, 2'b10, 0, 12'h0, 12'h0, 3'b000, 5'd0, 64'd0, 64'h9000_0000);
        do_reset();
        rd(12'h341); check("rst_mepc", last_rdata, 64'd0);
        rd(12'h300); check("rst_trap_mstatus", last_rdata, 64'h1800);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                drive($urandom_range(0, 1) == 1, 2'($urandom), 0, 12'h0, addrs[$urandom_range(0, 8)],
                      3'($urandom), 5'($urandom), {$urandom, $urandom}, 64'd0);
                do_reset();
            end else
                step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
                     addrs[$urandom_range(0, 8)], addrs[$urandom_range(0, 8)], 3'($urandom),
                     ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                     {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
